rr_rotate_arbiter_9: RTL
========================

Name: rr_rotate_arbiter_9

Overview:
- Round-robin arbiter that shares one resource among 9 requesters, such as wavefront slots feeding an issue port.
- Priority comes from rotating the request vector right by a pointer using one circular_barrel_shift_9b instance, then taking a fixed lowest-index-first pick.
- Holds each grant until the consumer acknowledges it, then moves the pointer past the winner.
- Sits between the per-slot ready logic and the single downstream consumer.

Parameters:
NUM_REQ, 9, requester count; fixed at 9 to match the shifter width; any other value is unsupported
ID_W, 4, width of gnt_id and ptr_out
TIMEOUT, 15, cycles an unacknowledged grant may stay before it is dropped (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
req  input  9  per-requester request level; bit i = requester i
flush  input  1  synchronous abort of the current grant
gnt_ack  input  1  consumer accepts the current grant this cycle
gnt_valid  output  1  a grant is presented
gnt_id  output  4  winner index, 0..8
gnt_onehot  output  9  one-hot form of gnt_id; all zero when gnt_valid=0
ptr_out  output  4  current priority pointer, 0..8
timeout  output  1  one-cycle pulse when a grant is dropped (ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst=0, async): state=IDLE, ptr=0, gnt_valid=0, gnt_id=0, gnt_onehot=0, timeout=0, timeout counter=0. Takes effect mid-grant with no drain.
- Arbitration function with pointer p:
  - rot = rotate_right(req_masked, p) through the shifter, shift_amt=p; so rot[k]=req_masked[(p+k) mod 9].
  - k = lowest set bit of rot.
  - winner = (p+k) mod 9; compute the mod by conditional subtract of 9; no divider.
  - p is always 0..8; shift amounts 9..15 must never reach the shifter (assert in simulation).
- FSM, two states, IDLE and GRANT:
  - IDLE: if |req, register winner (req_masked=req, p=ptr). Next cycle gnt_valid=1, gnt_id=winner, state=GRANT. Latency is 1 cycle from req sampled to gnt_valid. If req=0, stay IDLE.
  - GRANT, no ack: gnt_id and gnt_onehot stay stable. Dropping req does not revoke the grant; requesters must not rely on revocation.
  - GRANT, gnt_ack=1:
    - ptr <= (gnt_id+1) mod 9.
    - Re-arbitrate in the same cycle with p=(gnt_id+1) mod 9 and req_masked = req & ~gnt_onehot.
    - If any bit remains, the new winner is presented next cycle and the state stays GRANT. This gives back-to-back grants, one per cycle.
    - If no bit remains, go to IDLE with gnt_valid=0 next cycle.
- Ack while gnt_valid=0 is ignored.
- flush=1: next cycle state=IDLE, gnt_valid=0, gnt_onehot=0; ptr unchanged. flush has priority over gnt_ack in the same cycle; the ack is discarded.
- Outputs are registered only; there is no combinational path from req or gnt_ack to any output.
- ptr_out mirrors the ptr register.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter clears on every new grant and increments each cycle in GRANT without ack.
  - When the count reaches TIMEOUT-1 with no ack that cycle:
    - grant is dropped;
    - ptr <= (gnt_id+1) mod 9;
    - state=IDLE;
    - timeout pulses for 1 cycle, aligned with gnt_valid falling.
  - flush and reset clear the counter.
- Not defined:
  - No counter is present and timeout is tied 0.
  - A grant is held indefinitely until ack or flush.

Test Plan:
- Reset hold, then release with req=0 for 5 cycles -> gnt_valid=0, ptr_out=0. Assert rst low mid-GRANT -> all outputs 0 immediately, without waiting for clk.
- req=9'h1FF constant, gnt_ack=1 whenever gnt_valid -> gnt_id sequence 0,1,2,…,8,0,1 on consecutive cycles with no bubble; ptr_out follows at id+1 mod 9.
- Wrap-around: drive ptr to 5 (grant and ack id 4 with req=9'h010), then req=9'h084 (bits 2 and 7) with ack -> grants 7 then 2; ptr_out goes 8 then 3.
- Grant hold: req=9'h008, ack=0 for 10 cycles -> gnt_id=3, gnt_onehot=9'h008 stable. Drop req at cycle 4 -> still held. Ack at cycle 10 -> gnt_valid=0 next cycle, ptr_out=4.
- Flush/ack collision: in GRANT with id=6, assert flush=1 and gnt_ack=1 together -> gnt_valid=0 next cycle, ptr_out unchanged.
- ARB_TIMEOUT_EN with TIMEOUT=4: req=9'h002, no ack -> gnt_valid high 4 cycles, timeout pulses as gnt_valid falls, ptr_out=2. Same stimulus without the macro -> grant held, timeout=0.

Source files
------------

// File: rtl/rr_rotate_arbiter_9.sv
// Nine-way round-robin arbiter: rotate requests by the pointer, pick lowest index, hold until ack.
// Optional grant timeout is compiled in with `define ARB_TIMEOUT_EN.

module circular_barrel_shift_9b (
   input  logic [8:0] data_i,
   input  logic [3:0] shift_amt,
   output logic [8:0] data_o
);
   logic [8:0] s0, s1, s2;

   // Rotate right: data_o[k] = data_i[(k + shift_amt) mod 9] for shift_amt 0..8.
   assign s0     = shift_amt[0] ? {data_i[0],   data_i[8:1]} : data_i;
   assign s1     = shift_amt[1] ? {s0[1:0],     s0[8:2]}     : s0;
   assign s2     = shift_amt[2] ? {s1[3:0],     s1[8:4]}     : s1;
   assign data_o = shift_amt[3] ? {s2[7:0],     s2[8]}       : s2;
endmodule

module rr_rotate_arbiter_9 #(
   parameter int NUM_REQ = 9,
   parameter int ID_W    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               flush,
   input  logic               gnt_ack,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [ID_W-1:0]    ptr_out,
   output logic               timeout
);
   typedef enum logic {IDLE, GRANT} state_e;

   if (NUM_REQ != 9 || ID_W != 4 || TIMEOUT < 2) begin : g_cfg_err
      $error("rr_rotate_arbiter_9: unsupported parameter set");
   end

   state_e             state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [NUM_REQ-1:0] oh_q, oh_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;

   logic [NUM_REQ-1:0] arb_req, rot, win_oh;
   logic [ID_W-1:0]    arb_p, ptr_inc, k, winner;
   logic               arb_any;

   assign ptr_inc = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

   always_comb begin
      arb_req = req;
      arb_p   = ptr_q;
      if (state_q == GRANT) begin
         arb_req = req & ~oh_q;
         arb_p   = ptr_inc;
      end
   end

   circular_barrel_shift_9b u_shift (
      .data_i    (arb_req),
      .shift_amt (arb_p),
      .data_o    (rot)
   );

   // Lowest set bit of the rotated vector, then undo the rotation mod 9 without a divider.
   always_comb begin
      k = '0;
      for (int unsigned i = NUM_REQ; i > 0; i--) begin
         if (rot[i-1]) k = ID_W'(i - 1);
      end
      arb_any = |rot;
      winner  = (k >= ID_W'(NUM_REQ) - arb_p) ? arb_p + k - ID_W'(NUM_REQ) : arb_p + k;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         win_oh[i] = (winner == ID_W'(i));
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;
   logic             cnt_hit;

   assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      oh_d    = oh_q;
      ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
      to_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               state_d = GRANT;
               id_d    = winner;
               oh_d    = win_oh;
            end
         end
         GRANT: begin
            if (flush) begin
               state_d = IDLE;
               oh_d    = '0;
            end else if (gnt_ack) begin
               ptr_d = ptr_inc;
               if (arb_any) begin
                  id_d = winner;
                  oh_d = win_oh;
               end else begin
                  state_d = IDLE;
                  oh_d    = '0;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_hit) begin
               state_d = IDLE;
               oh_d    = '0;
               ptr_d   = ptr_inc;
               to_d    = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
`ifdef ARB_TIMEOUT_EN
      cnt_d = (state_q == GRANT && state_d == GRANT && !gnt_ack) ? cnt_q + CNT_W'(1) : '0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         id_q    <= '0;
         oh_q    <= '0;
         ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         oh_q    <= oh_d;
         ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         to_q    <= to_d;
`endif
      end
   end

   assign gnt_valid  = (state_q == GRANT);
   assign gnt_id     = id_q;
   assign gnt_onehot = oh_q;
   assign ptr_out    = ptr_q;
`ifdef ARB_TIMEOUT_EN
   assign timeout    = to_q;
`else
   assign timeout    = 1'b0;
`endif

   a_shift_range : assert property (@(posedge clk) disable iff (!rst)
      arb_p <= ID_W'(NUM_REQ - 1));
endmodule
